// File: rtl/multi_buffer_swap_controller.sv
// Multi-buffer swap controller: tracks ownership of 2..4 frame buffers
// between a rasterizer and a display scan-out engine, grants free buffers
// to the rasterizer and swaps finished frames onto the display either at
// vertical blank or immediately.
module multi_buffer_swap_controller #(
  parameter int NUM_BUFFERS   = 3,
  parameter int BUF_IDX_WIDTH = 2,
  parameter int SWAP_MODE     = 0
) (
  input  logic                     i_clk,
  input  logic                     i_srst_n,
  input  logic                     i_raster_start,
  input  logic                     i_raster_done,
  input  logic                     i_vblank,
  output logic                     o_raster_grant,
  output logic [BUF_IDX_WIDTH-1:0] o_raster_target,
  output logic [BUF_IDX_WIDTH-1:0] o_display_buffer,
  output logic                     o_new_frame,
  output logic                     o_dropped_frame,
  output logic [15:0]              o_frame_count
);

  typedef logic [BUF_IDX_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    BUF_FREE,
    BUF_RENDERING,
    BUF_READY,
    BUF_DISPLAYED
  } buf_state_t;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_OWN
  } rs_state_t;

  buf_state_t buf_state_q [NUM_BUFFERS];
  buf_state_t buf_state_d [NUM_BUFFERS];
  rs_state_t  rs_state_q, rs_state_d;
  idx_t       target_q, target_d;
  idx_t       display_q, display_d;
  logic [15:0] count_q, count_d;
  logic       new_frame_q, new_frame_d;
  logic       dropped_q, dropped_d;

  logic       free_found, ready_found;
  idx_t       free_idx, ready_idx;
  logic       swap_now, grant_now, done_now;

  // Locate the lowest-index FREE buffer and the (single) READY buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    // Scan high to low so the lowest matching index is the one left standing.
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (buf_state_q[i] == BUF_FREE) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
      if (buf_state_q[i] == BUF_READY) begin
        ready_found = 1'b1;
        ready_idx   = idx_t'(i);
      end
    end
  end

  // Rasterizer FSM next state, swap decision and per-buffer state updates.
  always_comb begin
    rs_state_d  = rs_state_q;
    target_d    = target_q;
    display_d   = display_q;
    count_d     = count_q;
    new_frame_d = 1'b0;
    dropped_d   = 1'b0;
    grant_now   = 1'b0;
    done_now    = 1'b0;

    // Swaps look only at registered state, so a frame finishing this cycle
    // cannot be shown until the next swap opportunity.
    swap_now = ready_found && ((SWAP_MODE != 0) || i_vblank);

    // A start that finds a free buffer grants on the very next edge; WAIT
    // only holds a request that arrived while nothing was free.
    unique case (rs_state_q)
      RS_IDLE, RS_WAIT: begin
        if ((rs_state_q == RS_WAIT) || i_raster_start) begin
          if (free_found) begin
            rs_state_d = RS_OWN;
            target_d   = free_idx;
            grant_now  = 1'b1;
          end else begin
            rs_state_d = RS_WAIT;
          end
        end
      end
      RS_OWN: begin
        if (i_raster_done) begin
          rs_state_d = RS_IDLE;
          done_now   = 1'b1;
        end
      end
      default: rs_state_d = RS_IDLE;
    endcase

    if (swap_now) begin
      display_d   = ready_idx;
      count_d     = count_q + 16'd1;
      new_frame_d = 1'b1;
    end

    // An unshown READY frame is replaced only when no swap takes it away.
    dropped_d = done_now && ready_found && !swap_now;

    for (int i = 0; i < NUM_BUFFERS; i++) begin
      buf_state_d[i] = buf_state_q[i];
      if (swap_now && (ready_idx == idx_t'(i))) begin
        buf_state_d[i] = BUF_DISPLAYED;
      end else if (swap_now && (display_q == idx_t'(i))) begin
        buf_state_d[i] = BUF_FREE;
      end else if (dropped_d && (ready_idx == idx_t'(i))) begin
        buf_state_d[i] = BUF_FREE;
      end
      if (grant_now && (free_idx == idx_t'(i))) begin
        buf_state_d[i] = BUF_RENDERING;
      end
      if (done_now && (target_q == idx_t'(i))) begin
        buf_state_d[i] = BUF_READY;
      end
    end
  end

  // State register with synchronous reset; in-flight frames are abandoned.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      // NOTE: the buffer state table is reset too -- ownership after reset must be known, not X.
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_state_q[i] <= (i == 0) ? BUF_DISPLAYED : BUF_FREE;
      end
      rs_state_q  <= RS_IDLE;
      target_q    <= '0;
      display_q   <= '0;
      count_q     <= '0;
      new_frame_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      buf_state_q <= buf_state_d;
      rs_state_q  <= rs_state_d;
      target_q    <= target_d;
      display_q   <= display_d;
      count_q     <= count_d;
      new_frame_q <= new_frame_d;
      dropped_q   <= dropped_d;
    end
  end

  assign o_raster_grant   = (rs_state_q == RS_OWN);
  assign o_raster_target  = target_q;
  assign o_display_buffer = display_q;
  assign o_new_frame      = new_frame_q;
  assign o_dropped_frame  = dropped_q;
  assign o_frame_count    = count_q;

endmodule
